jam_cost_server: RTL
====================

Name: jam_cost_server

Overview:
- Responder side of the job-assignment cost interface.
- Accepts an N x N cost matrix over a valid/ready write stream and stores it.
- Serves Cost combinationally to the job-assignment engine from the W/J worker/job address it drives.
- Captures the engine's final MinCost/MatchCount when its Valid rises, then reports completion.

Parameters:
N, 8, matrix dimension (workers = jobs = N); must be a power of two, address width log2(N)
CW, 7, cost entry width in bits
RW, 10, result cost width (MinCost)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous, active-high reset
clear  in  1  synchronous restart to LOAD from SERVE/DONE
in_valid  in  1  write-stream beat valid
in_ready  out  1  write-stream ready
in_data  in  CW  cost entry, row-major (worker-major) order
W  in  log2(N)  worker index from engine
J  in  log2(N)  job index from engine
Cost  out  CW  cost of (W,J)
Valid  in  1  engine result valid
MinCost  in  RW  engine minimum cost
MatchCount  in  4  engine count of minimum matches
table_ready  out  1  matrix fully loaded
res_cost  out  RW  latched MinCost
res_count  out  4  latched MatchCount
done  out  1  one-cycle pulse on result capture
err  out  1  sticky protocol error

Behaviour:
- Storage: N*N x CW register array. Not reset; contents are don't-care until written.
- wr_ptr: 2*log2(N) bits. Entry k is written to row k/N, column k%N.
- FSM states: LOAD, SERVE, DONE. Reset enters LOAD.
- Reset values: in_ready=1, table_ready=0, Cost=0, res_cost=0, res_count=0, done=0, err=0, wr_ptr=0.
- LOAD:
  - in_ready=1.
  - Each beat with in_valid&in_ready writes mem[wr_ptr]=in_data and increments wr_ptr.
  - On the beat with wr_ptr==N*N-1: wr_ptr wraps to 0; next cycle state=SERVE, in_ready=0, table_ready=1.
  - in_valid low: no write, no pointer change.
  - Cost held 0.
- SERVE:
  - in_ready=0. in_valid is ignored and memory is unchanged.
  - Cost = mem[W*N+J], purely combinational with zero cycle latency. The engine changes W/J on the rising edge and samples Cost on the falling edge, so Cost must settle within half a cycle.
  - On the first cycle Valid==1: res_cost<=MinCost, res_count<=MatchCount, done=1 for exactly that cycle, next state=DONE.
- DONE:
  - Cost continues to be served. table_ready stays 1.
  - Valid staying high does not re-capture or re-pulse done.
- clear:
  - In SERVE or DONE: next state=LOAD, wr_ptr=0, table_ready=0, in_ready=1, Cost=0. res_cost, res_count and err are retained.
  - Ignored in LOAD.
  - clear and Valid in the same SERVE cycle: clear wins, no capture, no done.
- err (sticky until RST):
  - Set if Valid==1 while in LOAD.
  - Set if in_valid==1 while in SERVE or DONE.
- Reset mid-load: wr_ptr returns to 0, and the matrix must be reloaded in full.
- No partial-table serving: table_ready never rises before all N*N beats are accepted.

Test Plan:
1. Load 64 beats, in_data=(k*3)%128 for k=0..63, in_valid held high:
   - table_ready rises the cycle after beat 63 and in_ready falls.
   - W=2,J=5 -> Cost=(21*3)%128=63; W=7,J=7 -> Cost=189%128=61.
2. Load with in_valid toggling 1/0 every cycle:
   - Exactly 64 accepted beats over 127 cycles, contents identical to scenario 1.
   - table_ready asserts only after the last accepted beat.
3. In SERVE, sweep W=0..7 with J=W:
   - Cost matches the diagonal entries on the same cycle the address changes.
   - in_valid=1 during the sweep with in_data=0 leaves memory unchanged and sets err.
4. In SERVE, drive MinCost=10'd345, MatchCount=4'd2, raise Valid and hold it 3 cycles:
   - res_cost=345, res_count=2, done high for exactly 1 cycle, state DONE.
5. Assert clear and Valid together in SERVE:
   - No capture and done stays 0.
   - FSM goes to LOAD, in_ready=1, table_ready=0, Cost=0.
6. Assert RST after 30 loaded beats, then load 64 new beats with in_data=63-k:
   - W=0,J=0 -> Cost=63; W=7,J=7 -> Cost=0.
   - err=0 and res_cost=0 after reset.

Source files
------------

// File: rtl/jam_cost_server.sv
// Cost-matrix responder for the job-assignment engine: loads an N x N matrix
// over a valid/ready stream, serves Cost combinationally, and latches the result.
module jam_cost_server #(
  parameter int N  = 8,
  parameter int CW = 7,
  parameter int RW = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_data,
  input  logic [$clog2(N)-1:0] W,
  input  logic [$clog2(N)-1:0] J,
  output logic [CW-1:0]        Cost,
  input  logic                 Valid,
  input  logic [RW-1:0]        MinCost,
  input  logic [3:0]           MatchCount,
  output logic                 table_ready,
  output logic [RW-1:0]        res_cost,
  output logic [3:0]           res_count,
  output logic                 done,
  output logic                 err
);

  localparam int AW = $clog2(N);
  localparam int PW = 2 * AW;

  typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   mem [N*N];
  logic            capture;
  logic            wr_en;

  assign wr_en       = (state == LOAD) && in_valid;
  assign in_ready    = (state == LOAD);
  assign table_ready = (state != LOAD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      LOAD:  if (wr_en && (wr_ptr == '1)) state_next = SERVE;
      SERVE: begin
        if (clear) state_next = LOAD;
        else if (Valid) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    if (clear) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Pointer wraps naturally to 0 on the last beat; clear re-zeroes it regardless.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             wr_ptr <= '0;
    else if (wr_en)                      wr_ptr <= wr_ptr + 1'b1;
    else if (clear && (state != LOAD))   wr_ptr <= '0;
  end

  // Matrix storage is intentionally unreset; contents are meaningless until loaded.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // N is a power of two, so {W,J} is the row-major index W*N+J.
  always_comb begin
    Cost = '0;
    if (state != LOAD) Cost = mem[{W, J}];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_cost  <= '0;
      res_count <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= capture;
      if (capture) begin
        res_cost  <= MinCost;
        res_count <= MatchCount;
      end
      if (((state == LOAD) && Valid) || ((state != LOAD) && in_valid))
        err <= 1'b1;
    end
  end

endmodule
